// File: rtl/id_ex_pipe_stage.sv
// ID/EX elastic pipeline stage: 2-entry skid buffer, sync flush, operand-B select at capture.
// Optional PC transport enabled by defining ID_EX_PIPE_PC_EN.
module id_ex_pipe_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 10,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               ALUSrc_i,
  input  logic               RegWrite_i,
  input  logic               MemWrite_i,
  input  logic               MemRead_i,
  input  logic               Mem2Reg_i,
  input  logic               Branch_i,
  input  logic [DATA_W-1:0]  RSdata_i,
  input  logic [DATA_W-1:0]  RTdata_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [REG_AW-1:0]  RDaddr_i,
  input  logic [REG_AW-1:0]  RSaddr_i,
  input  logic [REG_AW-1:0]  RTaddr_i,
`ifdef ID_EX_PIPE_PC_EN
  input  logic [DATA_W-1:0]  pc_i,
  output logic [DATA_W-1:0]  pc_o,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               RegWrite_o,
  output logic               MemWrite_o,
  output logic               MemRead_o,
  output logic               Mem2Reg_o,
  output logic               Branch_o,
  output logic [DATA_W-1:0]  RSdata_o,
  output logic [DATA_W-1:0]  opB_o,
  output logic [DATA_W-1:0]  RTdata_o,
  output logic [FUNCT_W-1:0] funct_o,
  output logic [REG_AW-1:0]  RDaddr_o,
  output logic [REG_AW-1:0]  RSaddr_o,
  output logic [REG_AW-1:0]  RTaddr_o
);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic               mem2reg;
    logic               branch;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W-1:0]  rt_data;
    logic [FUNCT_W-1:0] funct;
    logic [REG_AW-1:0]  rd_addr;
    logic [REG_AW-1:0]  rs_addr;
    logic [REG_AW-1:0]  rt_addr;
`ifdef ID_EX_PIPE_PC_EN
    logic [DATA_W-1:0]  pc;
`endif
  } entry_t;

  entry_t in_entry;
  entry_t main_q;
  entry_t skid_q;
  logic   main_v_q;
  logic   skid_v_q;
  logic   in_fire;
  logic   out_fire;

  assign in_ready_o  = ~skid_v_q & ~rst_i;
  assign out_valid_o = main_v_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = main_v_q & out_ready_i;

  // Operand B is resolved here so the execute stage sees a ready-to-use operand.
  always_comb begin
    in_entry           = '0;
    in_entry.alu_op    = ALUOp_i;
    in_entry.reg_write = RegWrite_i;
    in_entry.mem_write = MemWrite_i;
    in_entry.mem_read  = MemRead_i;
    in_entry.mem2reg   = Mem2Reg_i;
    in_entry.branch    = Branch_i;
    in_entry.rs_data   = RSdata_i;
    in_entry.opb       = ALUSrc_i ? imm_i : RTdata_i;
    in_entry.rt_data   = RTdata_i;
    in_entry.funct     = funct_i;
    in_entry.rd_addr   = RDaddr_i;
    in_entry.rs_addr   = RSaddr_i;
    in_entry.rt_addr   = RTaddr_i;
`ifdef ID_EX_PIPE_PC_EN
    in_entry.pc        = pc_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush_i) begin
      // Any input accepted this cycle is consumed and dropped.
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (!main_v_q) begin
      if (in_fire) begin
        main_q   <= in_entry;
        main_v_q <= 1'b1;
      end
    end else if (!skid_v_q) begin
      if (in_fire && out_fire) begin
        main_q <= in_entry;
      end else if (in_fire) begin
        skid_q   <= in_entry;
        skid_v_q <= 1'b1;
      end else if (out_fire) begin
        main_v_q <= 1'b0;
      end
    end else if (out_fire) begin
      main_q   <= skid_q;
      skid_v_q <= 1'b0;
    end
  end

  assign ALUOp_o    = main_q.alu_op;
  assign RegWrite_o = main_q.reg_write & main_v_q;
  assign MemWrite_o = main_q.mem_write & main_v_q;
  assign MemRead_o  = main_q.mem_read & main_v_q;
  assign Mem2Reg_o  = main_q.mem2reg;
  assign Branch_o   = main_q.branch & main_v_q;
  assign RSdata_o   = main_q.rs_data;
  assign opB_o      = main_q.opb;
  assign RTdata_o   = main_q.rt_data;
  assign funct_o    = main_q.funct;
  assign RDaddr_o   = main_q.rd_addr;
  assign RSaddr_o   = main_q.rs_addr;
  assign RTaddr_o   = main_q.rt_addr;
`ifdef ID_EX_PIPE_PC_EN
  assign pc_o       = main_q.pc;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed self-checking bench for id_ex_pipe_stage.
module tb_id_ex_pipe_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [1:0]  ALUOp_i, ALUOp_o;
  logic        ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i;
  logic        RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o;
  logic [31:0] RSdata_i, RTdata_i, imm_i, RSdata_o, opB_o, RTdata_o;
  logic [9:0]  funct_i, funct_o;
  logic [4:0]  RDaddr_i, RSaddr_i, RTaddr_i, RDaddr_o, RSaddr_o, RTaddr_o;
`ifdef ID_EX_PIPE_PC_EN
  logic [31:0] pc_i, pc_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .Mem2Reg_i(Mem2Reg_i),
    .Branch_i(Branch_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
    .funct_i(funct_i), .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
`ifdef ID_EX_PIPE_PC_EN
    .pc_i(pc_i), .pc_o(pc_o),
`endif
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ALUOp_o(ALUOp_o), .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o),
    .MemRead_o(MemRead_o), .Mem2Reg_o(Mem2Reg_o), .Branch_o(Branch_o),
    .RSdata_o(RSdata_o), .opB_o(opB_o), .RTdata_o(RTdata_o), .funct_o(funct_o),
    .RDaddr_o(RDaddr_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o)
  );

  task automatic idle_inputs();
    flush_i = 0; in_valid_i = 0; ALUOp_i = 0; ALUSrc_i = 0;
    RegWrite_i = 0; MemWrite_i = 0; MemRead_i = 0; Mem2Reg_i = 0; Branch_i = 0;
    RSdata_i = 0; RTdata_i = 0; imm_i = 0; funct_i = 0;
    RDaddr_i = 0; RSaddr_i = 0; RTaddr_i = 0;
`ifdef ID_EX_PIPE_PC_EN
    pc_i = 0;
`endif
  endtask

  // Advance one clock; return at the falling edge with outputs settled.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic present(input logic [4:0] rd, input logic [31:0] rs, input logic mw);
    in_valid_i = 1; RDaddr_i = rd; RSdata_i = rs; MemWrite_i = mw;
    ALUOp_i = 2'b10; Mem2Reg_i = 1; funct_i = 10'h2a; RTaddr_i = 5'd7; RTdata_i = 32'h77;
`ifdef ID_EX_PIPE_PC_EN
    pc_i = {27'd0, rd} << 2;
`endif
  endtask

  task automatic test_reset();
    idle_inputs(); out_ready_i = 1; rst_i = 1;
    step(); step();
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid_o); end
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready_o); end
    checks++;
    if ({opB_o, RDaddr_o, RegWrite_o} !== 38'd0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", {opB_o, RDaddr_o, RegWrite_o});
    end
    rst_i = 0; #1;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", in_ready_o); end
  endtask

  task automatic test_single_op();
    idle_inputs(); out_ready_i = 1;
    in_valid_i = 1; ALUSrc_i = 1; imm_i = 32'h10; RTdata_i = 32'h5; RegWrite_i = 1;
    step();
    idle_inputs(); #1;
    checks++;
    if ({out_valid_o, opB_o, RTdata_o, RegWrite_o} !== {1'b1, 32'h10, 32'h5, 1'b1}) begin
      failures++;
      $display("FAIL single_op got v=%0b opB=%0h rt=%0h rw=%0b exp v=1 opB=10 rt=5 rw=1",
               out_valid_o, opB_o, RTdata_o, RegWrite_o);
    end
    step(); #1;
    checks++;
    if ({out_valid_o, RegWrite_o} !== 2'b00) begin
      failures++; $display("FAIL bubble_gate got v=%0b rw=%0b exp 0 0", out_valid_o, RegWrite_o);
    end
  endtask

  task automatic test_alusrc_rt();
    idle_inputs(); out_ready_i = 1;
    in_valid_i = 1; ALUSrc_i = 0; imm_i = 32'hdead; RTdata_i = 32'h1234;
    step(); idle_inputs(); #1;
    checks++;
    if (opB_o !== 32'h1234) begin failures++; $display("FAIL alusrc_rt got=%0h exp=1234", opB_o); end
    step();
  endtask

  task automatic test_streaming();
    idle_inputs(); out_ready_i = 1;
    for (int i = 1; i <= 8; i++) begin
      present(5'(i), 32'(i * 3), 1'b0);
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=0 exp=1", i); end
      if (i > 1) begin
        checks++;
        if ({out_valid_o, RDaddr_o} !== {1'b1, 5'(i - 1)}) begin
          failures++;
          $display("FAIL stream_out got v=%0b rd=%0d exp v=1 rd=%0d", out_valid_o, RDaddr_o, i - 1);
        end
      end
      step();
    end
    idle_inputs(); #1;
    checks++;
    if ({out_valid_o, RDaddr_o} !== {1'b1, 5'd8}) begin
      failures++; $display("FAIL stream_last got v=%0b rd=%0d exp v=1 rd=8", out_valid_o, RDaddr_o);
    end
    step(); #1;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL stream_drain got=1 exp=0"); end
  endtask

  task automatic test_stall_skid();
    idle_inputs(); out_ready_i = 0;
    present(5'd10, 32'hA, 1'b1);
    step();
    present(5'd11, 32'hB, 1'b0); #1;
    checks++;
    if ({out_valid_o, RDaddr_o, in_ready_o} !== {1'b1, 5'd10, 1'b1}) begin
      failures++;
      $display("FAIL skid_one got v=%0b rd=%0d rdy=%0b exp 1 10 1", out_valid_o, RDaddr_o, in_ready_o);
    end
    step();
    present(5'd12, 32'hC, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({in_ready_o, RDaddr_o, RSdata_o, MemWrite_o} !== {1'b0, 5'd10, 32'hA, 1'b1}) begin
        failures++;
        $display("FAIL skid_hold k=%0d got rdy=%0b rd=%0d rs=%0h mw=%0b exp 0 10 a 1",
                 k, in_ready_o, RDaddr_o, RSdata_o, MemWrite_o);
      end
      step();
    end
    idle_inputs(); out_ready_i = 1;
    step(); #1;
    checks++;
    if ({out_valid_o, RDaddr_o, RSdata_o, MemWrite_o, in_ready_o} !== {1'b1, 5'd11, 32'hB, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL skid_release got v=%0b rd=%0d rs=%0h mw=%0b rdy=%0b exp 1 11 b 0 1",
               out_valid_o, RDaddr_o, RSdata_o, MemWrite_o, in_ready_o);
    end
    step(); #1;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL skid_empty got=1 exp=0"); end
  endtask

  task automatic test_flush();
    idle_inputs(); out_ready_i = 0;
    present(5'd20, 32'h20, 1'b1); step();
    present(5'd21, 32'h21, 1'b1); step();
    present(5'd22, 32'h22, 1'b1); flush_i = 1;
    step();
    idle_inputs(); #1;
    checks++;
    if ({out_valid_o, MemWrite_o, in_ready_o} !== 3'b001) begin
      failures++;
      $display("FAIL flush_full got v=%0b mw=%0b rdy=%0b exp 0 0 1", out_valid_o, MemWrite_o, in_ready_o);
    end
    present(5'd23, 32'h23, 1'b0); step();
    present(5'd24, 32'h24, 1'b1); flush_i = 1; #1;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_one_ready got=0 exp=1"); end
    step();
    idle_inputs(); out_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'b0) begin
        failures++; $display("FAIL flush_discard k=%0d got v=1 rd=%0d exp v=0", k, RDaddr_o);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); out_ready_i = 0;
    present(5'd30, 32'h30, 1'b1); ALUSrc_i = 1; imm_i = 32'h99; step();
    present(5'd31, 32'h31, 1'b1); step();
    idle_inputs(); rst_i = 1; #1;
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=1 exp=0"); end
    step(); #1;
    checks++;
    if ({out_valid_o, RDaddr_o, RSdata_o, opB_o, RTdata_o, funct_o, ALUOp_o, Mem2Reg_o,
         RTaddr_o, MemWrite_o, in_ready_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got v=%0b rd=%0d rs=%0h opB=%0h rt=%0h fn=%0h op=%0h m2r=%0b exp all 0",
               out_valid_o, RDaddr_o, RSdata_o, opB_o, RTdata_o, funct_o, ALUOp_o, Mem2Reg_o);
    end
    rst_i = 0; out_ready_i = 1;
    step(); #1;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_skid got v=1 exp=0"); end
  endtask

`ifdef ID_EX_PIPE_PC_EN
  task automatic test_pc();
    idle_inputs(); out_ready_i = 0;
    present(5'd1, 32'h1, 1'b0); pc_i = 32'h100; step();
    present(5'd2, 32'h2, 1'b0); pc_i = 32'h104; step();
    idle_inputs(); #1;
    checks++;
    if ({pc_o, RDaddr_o} !== {32'h100, 5'd1}) begin
      failures++; $display("FAIL pc_first got pc=%0h rd=%0d exp 100 1", pc_o, RDaddr_o);
    end
    out_ready_i = 1; step(); #1;
    checks++;
    if ({out_valid_o, pc_o, RDaddr_o} !== {1'b1, 32'h104, 5'd2}) begin
      failures++; $display("FAIL pc_second got pc=%0h rd=%0d exp 104 2", pc_o, RDaddr_o);
    end
    step();
  endtask
`endif

  initial begin
    rst_i = 1; out_ready_i = 1; idle_inputs();
    @(negedge clk_i);
    test_reset();
    test_single_op();
    test_alusrc_rt();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_reset_mid();
`ifdef ID_EX_PIPE_PC_EN
    test_pc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
